// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, engine state encoding and sizing helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Never returns less than 1 so every counter has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  function automatic int unsigned calc_cycles(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    return (mode == PAR_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready payload handshake between a byte source and the UART transmitter.
interface uart_tx_stream_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: load restarts a CYCLES-long period, tick marks its last clock.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = clog2(CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CntMax;
    end else if (!tick_o) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Parametrised UART transmitter with valid/ready input and a one-entry holding buffer
// so that queued frames leave back-to-back.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12000000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_stream_if.slave in_if,
  output logic            tx_o,
  output logic            busy_o,
  output logic            frame_done_o
);

  localparam int unsigned     CYCLES  = calc_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned     BitW    = clog2(DATA_BITS + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  if (CYCLES < 2) begin : gen_err_cycles
    $error("uart_tx_stream: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_err_data_bits
    $error("uart_tx_stream: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : gen_err_parity
    $error("uart_tx_stream: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_err_stop_bits
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_int_n = rst_sync_q[1];

  uart_state_e          state_q, state_d;
  logic                 hold_full_q, hold_full_d;
  logic                 in_ready_q;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 baud_load, baud_tick;
  logic                 accept, last_stop, frame_end, load;

  uart_baud_tick #(
    .CYCLES(CYCLES)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_int_n),
    .load_i(baud_load),
    .tick_o(baud_tick)
  );

  assign accept    = in_if.in_valid && in_ready_q;
  assign last_stop = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;
  assign frame_end = (state_q == StStop) && baud_tick && last_stop;
  assign load      = hold_full_q && ((state_q == StIdle) || frame_end);

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    done_d      = 1'b0;
    baud_load   = 1'b0;

    if (accept) begin
      hold_d      = in_if.in_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
      end
      StStart: begin
        if (baud_tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
          baud_load = 1'b1;
        end
      end
      StData: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitW'(1);
          baud_load = 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d    = (PARITY != PAR_NONE) ? StParity : StStop;
            stop_cnt_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
          baud_load  = 1'b1;
        end
      end
      StStop: begin
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (baud_tick) begin
          stop_cnt_d = 1'b1;
          baud_load  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A waiting frame starts on the very edge the previous one ends.
    if (load) begin
      shift_d     = hold_q;
      parity_d    = parity_bit(9'(hold_q), PARITY);
      hold_full_d = 1'b0;
      state_d     = StStart;
      bit_cnt_d   = '0;
      stop_cnt_d  = 1'b0;
      baud_load   = 1'b1;
    end

    case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= StIdle;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      hold_q      <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= !hold_full_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign tx_o           = tx_q;
  assign busy_o         = (state_q != StIdle) || hold_full_q;
  assign frame_done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four configurations (8N1, 8E1, 8O1, 7N2) at 10 clocks per bit,
// line waveform compared against a frame model built from the bit-level frame format.
module tb_uart_tx_stream;

  localparam int unsigned ClkFreq = 1000000;
  localparam int unsigned Baud    = 100000;
  localparam int          Cyc     = 10;
  localparam int          NumDut  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NumDut-1:0] vld;
  logic [8:0]        dat [NumDut];
  logic [NumDut-1:0] rdy, txs, bsy, fds;

  uart_tx_stream_if #(.DATA_BITS(8)) if0 ();
  uart_tx_stream_if #(.DATA_BITS(8)) if1 ();
  uart_tx_stream_if #(.DATA_BITS(8)) if2 ();
  uart_tx_stream_if #(.DATA_BITS(7)) if3 ();

  assign if0.in_valid = vld[0];
  assign if1.in_valid = vld[1];
  assign if2.in_valid = vld[2];
  assign if3.in_valid = vld[3];
  assign if0.in_data  = dat[0][7:0];
  assign if1.in_data  = dat[1][7:0];
  assign if2.in_data  = dat[2][7:0];
  assign if3.in_data  = dat[3][6:0];
  assign rdy[0]       = if0.in_ready;
  assign rdy[1]       = if1.in_ready;
  assign rdy[2]       = if2.in_ready;
  assign rdy[3]       = if3.in_ready;

  uart_tx_stream #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_if(if0), .tx_o(txs[0]), .busy_o(bsy[0]),
    .frame_done_o(fds[0]));
  uart_tx_stream #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(if1), .tx_o(txs[1]), .busy_o(bsy[1]),
    .frame_done_o(fds[1]));
  uart_tx_stream #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_if(if2), .tx_o(txs[2]), .busy_o(bsy[2]),
    .frame_done_o(fds[2]));
  uart_tx_stream #(.CLK_FREQ(ClkFreq), .BAUD_RATE(Baud), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_if(if3), .tx_o(txs[3]), .busy_o(bsy[3]),
    .frame_done_o(fds[3]));

  function automatic int cfg_bits(input int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int k);
    return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
  endfunction
  function automatic int cfg_stop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  int errors = 0;
  int checks = 0;

  bit   exp_tx[$], exp_fd[$], exp_bsy[$];
  logic rec_tx[$], rec_fd[$], rec_bsy[$], rec_rdy[$];
  logic rec_on = 1'b0;
  int   rec_k = 0;

  // Sample index 0 is the cycle right after the accepting edge.
  always @(negedge clk) begin
    if (rec_on) begin
      rec_tx.push_back(txs[rec_k]);
      rec_fd.push_back(fds[rec_k]);
      rec_bsy.push_back(bsy[rec_k]);
      rec_rdy.push_back(rdy[rec_k]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check_seq(input string name, input logic got[$], input bit want[$]);
    int bad;
    bad = -1;
    for (int i = 0; i < want.size(); i++) begin
      if (bad < 0 && (i >= got.size() || got[i] !== logic'(want[i]))) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s at sample %0d: got %b expected %b", name, bad,
               (bad < got.size()) ? got[bad] : 1'bx, want[bad]);
    end
  endtask

  task automatic begin_exp();
    exp_tx.delete(); exp_fd.delete(); exp_bsy.delete();
    rec_tx.delete(); rec_fd.delete(); rec_bsy.delete(); rec_rdy.delete();
    repeat (2) begin
      exp_tx.push_back(1'b1); exp_fd.push_back(1'b0); exp_bsy.push_back(1'b1);
    end
  endtask

  // Frame model: start, payload LSB first, optional parity, stop bits; each bit Cyc clocks.
  task automatic add_frame(input int k, input logic [8:0] d);
    bit b[$];
    int ones;
    b.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < cfg_bits(k); i++) begin
      b.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_par(k) != 0) b.push_back(((ones % 2) == 1) ^ (cfg_par(k) == 2));
    for (int i = 0; i < cfg_stop(k); i++) b.push_back(1'b1);
    foreach (b[i]) begin
      repeat (Cyc) begin
        exp_tx.push_back(b[i]); exp_fd.push_back(1'b0); exp_bsy.push_back(1'b1);
      end
    end
    exp_fd[exp_fd.size() - 1] = 1'b1;
  endtask

  task automatic finish_exp();
    exp_bsy[exp_bsy.size() - 1] = 1'b0;
    repeat (3) begin
      exp_tx.push_back(1'b1); exp_fd.push_back(1'b0); exp_bsy.push_back(1'b0);
    end
  endtask

  task automatic accept_one(input int k, input logic [8:0] d, output bit ok);
    int t;
    t  = 0;
    ok = 1'b1;
    while (!rdy[k] && t < 400) begin
      @(posedge clk); #1; t++;
    end
    if (!rdy[k]) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: got ready=0 expected ready=1", k);
      ok = 1'b0;
      return;
    end
    vld[k] = 1'b1;
    dat[k] = d;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    dat[k] = 9'($urandom);
  endtask

  task automatic wait_rec();
    int t;
    t = 0;
    while (rec_tx.size() < exp_tx.size() && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    rec_on = 1'b0;
  endtask

  task automatic compare_rec(input string name);
    check_seq({name, "_tx"}, rec_tx, exp_tx);
    check_seq({name, "_frame_done"}, rec_fd, exp_fd);
    check_seq({name, "_busy"}, rec_bsy, exp_bsy);
  endtask

  task automatic send_check(input int k, input logic [8:0] d, input string name);
    bit ok;
    begin_exp(); add_frame(k, d); finish_exp();
    accept_one(k, d, ok);
    if (ok) begin
      rec_k = k; rec_on = 1'b1;
      wait_rec();
      compare_rec(name);
    end
  endtask

  typedef struct {
    int         k;
    logic [8:0] data;
    int         exp_len;
    int         exp_par;  // -1 when the configuration has no parity bit
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   s, f, pos, delay, bad;
    bit   ok, got;
    logic [8:0] d;

    vecs[0] = '{0, 9'h055, 100, -1};
    vecs[1] = '{1, 9'h007, 110, 1};
    vecs[2] = '{2, 9'h007, 110, 0};
    vecs[3] = '{3, 9'h07F, 100, -1};
    vecs[4] = '{1, 9'h000, 110, 0};
    vecs[5] = '{2, 9'h000, 110, 1};

    rst_n = 1'b0;
    vld   = '0;
    for (int k = 0; k < NumDut; k++) dat[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NumDut; k++)
      check($sformatf("reset_state_dut%0d", k), {txs[k], bsy[k], rdy[k], fds[k]}, 4'b1010);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < NumDut; k++)
      check($sformatf("post_reset_dut%0d", k), {txs[k], bsy[k], rdy[k], fds[k]}, 4'b1010);

    for (int v = 0; v < 6; v++) begin
      send_check(vecs[v].k, vecs[v].data, $sformatf("vec%0d", v));
      s = -1; f = -1;
      for (int i = 0; i < rec_tx.size(); i++) begin
        if (s < 0 && rec_tx[i] === 1'b0) s = i;
        if (f < 0 && rec_fd[i] === 1'b1) f = i;
      end
      check($sformatf("vec%0d_len", v), 32'(f - s + 1), 32'(vecs[v].exp_len));
      if (vecs[v].exp_par >= 0) begin
        pos = s + (1 + cfg_bits(vecs[v].k)) * Cyc + Cyc / 2;
        check($sformatf("vec%0d_parity", v), 32'(rec_tx[pos]), 32'(vecs[v].exp_par));
      end
    end

    // Back-to-back frames, then backpressure with the hold full of 0x3C.
    begin_exp(); add_frame(0, 9'h0A5); add_frame(0, 9'h03C); finish_exp();
    accept_one(0, 9'h0A5, ok);
    rec_k = 0; rec_on = 1'b1;
    vld[0] = 1'b1; dat[0] = 9'h03C; delay = 0;
    while (delay < 10) begin
      got = rdy[0];
      @(posedge clk); #1;
      delay++;
      if (got) break;
    end
    check("b2b_accept_delay", 32'(delay >= 1 && delay <= 2), 32'd1);
    for (int i = 0; i < 40; i++) begin
      dat[0] = (i % 2 == 1) ? 9'h022 : 9'h011;
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    wait_rec();
    compare_rec("b2b");
    bad = -1;
    for (int r = 2; r <= 101; r++)
      if (bad < 0 && (r >= rec_rdy.size() || rec_rdy[r] !== logic'(r == 101))) bad = r;
    check("b2b_ready_first_bad_sample", 32'(bad), 32'hFFFF_FFFF);

    // Reset in frame cycle 35 of a 0x00 frame.
    begin_exp();
    accept_one(0, 9'h000, ok);
    repeat (36) @(posedge clk);
    #1;
    check("rst_pre_tx", 32'(txs[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {txs[0], bsy[0], rdy[0], fds[0]}, 4'b1010);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_check(0, 9'h081, "after_reset");

    for (int i = 0; i < 16; i++) begin
      int k;
      k = int'($urandom_range(0, 3));
      d = 9'($urandom) & ((9'd1 << cfg_bits(k)) - 9'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_check(k, d, $sformatf("rand%0d_dut%0d", i, k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
